// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared direction/state types for the frog move path.
package frogger_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COOL  = 2'd2
  } state_t;

  localparam int NUM_DIRS = 4;

  // Round-robin successor; relies on the natural 2-bit wrap.
  function automatic dir_t dir_after(dir_t d);
    logic [1:0] nxt;
    nxt = 2'(d) + 2'd1;
    return dir_t'(nxt);
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin pick of same-cycle presses.
module rr_arbiter4
  import frogger_pkg::*;
(
  input  logic [NUM_DIRS-1:0] req,
  input  dir_t                last_dir,
  output logic                grant_valid,
  output dir_t                grant_dir,
  output logic                lose_any
);

  dir_t cand;
  logic found;

  always_comb begin
    grant_dir = UP;
    found     = 1'b0;
    cand      = last_dir;
    // Walk the ring starting one past the last winner.
    for (int k = 0; k < NUM_DIRS; k++) begin
      cand = dir_after(cand);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_dir = cand;
      end
    end
  end

  assign grant_valid = |req;
  assign lose_any    = (req & (req - 4'd1)) != 4'd0;

endmodule

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - rate-limited single move command from four press pulses.
module move_arbiter
  import frogger_pkg::*;
#(
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic press_up,
  input  logic press_down,
  input  logic press_left,
  input  logic press_right,
  input  logic move_ready,
  output logic move_valid,
  output dir_t move_dir,
  output logic dropped
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic             pend_valid_q, pend_valid_d;
  dir_t             pend_dir_q, pend_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             last_dir_q, last_dir_d;
  logic             dropped_q, dropped_d;

  logic [NUM_DIRS-1:0] req;
  logic                grant_valid;
  dir_t                grant_dir;
  logic                lose_any;
  logic                launch;
  logic                to_pending;

  assign req = {press_right, press_left, press_down, press_up};

  rr_arbiter4 u_rr (
    .req         (req),
    .last_dir    (last_dir_q),
    .grant_valid (grant_valid),
    .grant_dir   (grant_dir),
    .lose_any    (lose_any)
  );

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    cnt_d        = cnt_q;
    last_dir_d   = last_dir_q;
    dropped_d    = 1'b0;
    launch       = 1'b0;
    to_pending   = 1'b0;

    if (!enable) begin
      state_d      = IDLE;
      pend_valid_d = 1'b0;
    end else begin
      dropped_d = lose_any;
      case (state_q)
        IDLE:  launch = 1'b1;
        ISSUE: begin
          to_pending = 1'b1;
          if (move_ready) begin
            state_d = COOL;
            cnt_d   = CNT_LOAD;
          end
        end
        COOL: begin
          if (cnt_q != '0) begin
            cnt_d      = cnt_q - CNT_W'(1);
            to_pending = 1'b1;
          end else begin
            launch = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Launch point: the buffered move goes out first, a new winner refills pending.
      if (launch) begin
        if (pend_valid_q) begin
          dir_d        = pend_dir_q;
          state_d      = ISSUE;
          pend_valid_d = 1'b0;
          to_pending   = 1'b1;
        end else if (grant_valid) begin
          dir_d      = grant_dir;
          last_dir_d = grant_dir;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end

      if (to_pending && grant_valid) begin
        if (!pend_valid_d) begin
          pend_valid_d = 1'b1;
          pend_dir_d   = grant_dir;
          last_dir_d   = grant_dir;
        end else begin
          dropped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dir_q        <= UP;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= UP;
      cnt_q        <= '0;
      last_dir_q   <= RIGHT;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      cnt_q        <= cnt_d;
      last_dir_q   <= last_dir_d;
      dropped_q    <= dropped_d;
    end
  end

  assign move_valid = (state_q == ISSUE);
  assign move_dir   = dir_q;
  assign dropped    = dropped_q;

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Turns the four direction one-shot press pulses into a single rate-limited move command for the frog-position logic. Arbitrates simultaneous presses round-robin, buffers one pending move, and presents it on a valid/ready handshake. A cooldown counter enforces a minimum spacing between accepted hops. Sits between the four per-key edge-detect/synchroniser stages and the game-board update logic.

## Interface
- `COOLDOWN`, default 8: idle cycles enforced after each accepted move. Legal range is 1..255.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `enable` in 1: game running. Low means flush and ignore presses.
- `press_up`, `press_down`, `press_left`, `press_right` in 1 each: single-cycle press pulses.
- `move_ready` in 1: consumer accepts the move this cycle.
- `move_valid` out 1: move command valid.
- `move_dir` out 2: `dir_t` (UP=0, DOWN=1, LEFT=2, RIGHT=3). Held stable while `move_valid` is high.
- `dropped` out 1: registered pulse, high one cycle after any press was discarded.

## Operation
- FSM states:
  - IDLE: `move_valid`=0.
  - ISSUE: `move_valid`=1.
  - COOL: `move_valid`=0, counter running.
- Arbitration applies to presses arriving in the same cycle.
  - Round-robin pointer `last_dir`. Search order starts at `last_dir`+1 mod 4.
  - The winner updates `last_dir` whenever it is captured.
  - All losers are discarded and set `dropped` for that cycle.
- Capture rules, for a cycle with at least one press and `enable`=1:
  - IDLE: the winner loads `move_dir` directly; next state ISSUE.
  - ISSUE, or COOL not on its final cycle: the winner goes to the pending register if it is empty. If pending is full, the winner is also dropped; the oldest pending move is kept.
  - COOL on its final cycle (`cnt`==0): if pending is full, pending goes to `move_dir`, pending is cleared, next state ISSUE, and the new winner then fills pending. If pending is empty, the winner goes straight to `move_dir` and next state is ISSUE.
- ISSUE with `move_ready`=1 is a handshake. Next state COOL with `cnt` loaded to `COOLDOWN`-1.
- COOL decrements `cnt` each cycle. At `cnt`==0 the next state is ISSUE if a move is available (pending or new), else IDLE.
- IDLE with pending full: pending goes to `move_dir`, next state ISSUE. This only arises after an edge case; the normal path leaves IDLE via COOL.
- `enable`=0 takes priority over everything except `reset`:
  - Next state IDLE and pending cleared.
  - Presses are ignored and do not raise `dropped`.
  - An in-flight ISSUE is abandoned without a handshake.
  - `last_dir` is kept.
- Reset values:
  - Outputs: `move_valid`=0, `move_dir`=UP, `dropped`=0.
  - Internal: state IDLE, pending empty, `cnt`=0, `last_dir`=RIGHT, so UP wins first.
- Widths:
  - `cnt` is $clog2(`COOLDOWN`) bits, minimum 1.
  - Pointer increment wraps mod 4 (2-bit natural wrap).

## Timing
- Press in cycle N while IDLE gives `move_valid`=1 from cycle N+1, i.e. 1-cycle latency.
- Handshake in cycle H: `move_valid`=0 for cycles H+1..H+`COOLDOWN`. The earliest next `move_valid` is cycle H+`COOLDOWN`+1.
- `move_valid` may be high for many cycles; `move_dir` must not change until the handshake.
- `dropped` for discards in cycle N is high in cycle N+1 only.
- `reset` or `enable` low in cycle N gives `move_valid`=0 in cycle N+1.

## Structure
- `frogger_pkg` holds:
  - `dir_t` enum typedef, 2-bit, UP/DOWN/LEFT/RIGHT.
  - `state_t` enum typedef (IDLE/ISSUE/COOL).
- Sub-module `rr_arbiter4`:
  - Purely combinational.
  - Inputs: 4-bit request vector and `last_dir`.
  - Outputs: `grant_valid`, `grant_dir`, and a `lose_any` flag.
- Pending register, FSM and counter live in `move_arbiter`.

## Test plan
- Reset, then `press_up` in cycle 2 → `move_valid`=1, `move_dir`=UP in cycle 3. `move_ready` in cycle 5 → `move_valid` low in cycles 6..13 (`COOLDOWN`=8).
- `press_up` and `press_left` in the same cycle from reset → UP issued and `dropped`=1 the next cycle. Repeat the same pair after cooldown → LEFT issued (pointer moved past UP).
- While in ISSUE, `press_down` and then `press_right` on later cycles → DOWN pending, RIGHT dropped. After handshake + 8 cycles → DOWN issued without a new press.
- Hold `move_ready`=0 for 20 cycles in ISSUE → `move_valid` and `move_dir` stay constant. Handshake on cycle 21 → COOL.
- Deassert `enable` mid-ISSUE with pending full → next cycle `move_valid`=0 and pending empty. Press with `enable`=0 → no output and `dropped`=0.
- Assert `reset` during COOL with `cnt`=4 → next cycle state is IDLE and outputs are at their reset values. A press one cycle later → issued with 1-cycle latency.
